// File: rtl/dino_pkg.sv
// Shared register map, sequencer state type and scroll arithmetic for the obstacle writer.
// Macro SCORE_WRITE_EN adds the score register write to the end of each frame's sequence.
package dino_pkg;

  localparam logic [8:0] REG_SCAC_X     = 9'd6;
  localparam logic [8:0] REG_GODZILLA_X = 9'd8;
  localparam logic [8:0] REG_SCORE      = 9'd10;

  typedef enum logic [1:0] {IDLE, UPDATE, WRITE} wr_state_t;

`ifdef SCORE_WRITE_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif

  // Step a position left by speed, wrapping back in from the right edge of the screen.
  function automatic logic [9:0] scroll_step(input logic [9:0] x, input logic [3:0] speed,
                                             input logic [9:0] screen_w);
    logic [9:0] spd;
    spd = {6'd0, speed};
    return (x >= spd) ? (x - spd) : (x + screen_w - spd);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick from the falling edge of vga_vs, plus the frames-per-score divider.
// Macro SCORE_WRITE_EN adds the divider and its score_step output.
module frame_tick_gen
`ifdef SCORE_WRITE_EN
#(
  parameter int unsigned SCORE_FRAMES = 60
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic vga_vs,
`ifdef SCORE_WRITE_EN
  input  logic advance,
  output logic score_step,
`endif
  output logic tick
);

  logic vs_q;

  always_ff @(posedge clk) begin
    if (!reset_n) vs_q <= 1'b1;
    else          vs_q <= vga_vs;
  end

  assign tick = vs_q & ~vga_vs;

`ifdef SCORE_WRITE_EN
  localparam int DIV_W = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_FRAMES - 1);

  logic [DIV_W-1:0] frame_div;

  // The divider only counts frames that actually run an update sequence.
  assign score_step = advance && (frame_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n)     frame_div <= '0;
    else if (advance) frame_div <= score_step ? '0 : (frame_div + DIV_W'(1));
  end
`endif

endmodule

// File: rtl/obstacle_scroll_writer.sv
// Per-frame obstacle scroller that writes cactus/godzilla X (and optionally score) to the sprite peripheral.
// Macro SCORE_WRITE_EN enables the score counter and its third register write.
module obstacle_scroll_writer
  import dino_pkg::*;
#(
  parameter logic [9:0] SCREEN_W = 10'd640,
  parameter logic [9:0] CAC_INIT = 10'd500,
  parameter logic [9:0] GOD_INIT = 10'd100
`ifdef SCORE_WRITE_EN
  ,
  parameter int unsigned SCORE_FRAMES = 60
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_vs,
  input  logic        enable,
  input  logic [3:0]  speed,
  input  logic        waitrequest,
  output logic        chipselect,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        overrun
);

  wr_state_t   state;
  logic [1:0]  idx;
  logic [9:0]  cac_x, god_x;
  logic [9:0]  cac_nx, god_nx;
  logic        tick;
  logic [8:0]  next_addr;
  logic [31:0] next_data;

`ifdef SCORE_WRITE_EN
  logic [3:0] score;
  logic [3:0] score_nx;
  logic       score_step;

  frame_tick_gen #(.SCORE_FRAMES(SCORE_FRAMES)) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .vga_vs     (vga_vs),
    .advance    (state == UPDATE),
    .score_step (score_step),
    .tick       (tick)
  );

  assign score_nx = (score == 4'd9) ? 4'd0 : (score + 4'd1);
`else
  frame_tick_gen u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .vga_vs  (vga_vs),
    .tick    (tick)
  );
`endif

  assign cac_nx = scroll_step(cac_x, speed, SCREEN_W);
  assign god_nx = scroll_step(god_x, speed, SCREEN_W);

  // Entry that follows the one currently on the bus; idx 0 is loaded directly from UPDATE.
  always_comb begin
    next_addr = REG_GODZILLA_X;
    next_data = {22'd0, god_x};
`ifdef SCORE_WRITE_EN
    if (idx == 2'd1) begin
      next_addr = REG_SCORE;
      next_data = {28'd0, score};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cac_x      <= CAC_INIT;
      god_x      <= GOD_INIT;
      chipselect <= 1'b0;
      write      <= 1'b0;
      address    <= 9'd0;
      writedata  <= 32'd0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef SCORE_WRITE_EN
      score      <= 4'd0;
`endif
    end else begin
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            state <= UPDATE;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          cac_x      <= cac_nx;
          god_x      <= god_nx;
`ifdef SCORE_WRITE_EN
          if (score_step) score <= score_nx;
`endif
          idx        <= 2'd0;
          chipselect <= 1'b1;
          write      <= 1'b1;
          address    <= REG_SCAC_X;
          writedata  <= {22'd0, cac_nx};
          state      <= WRITE;
        end
        WRITE: begin
          // Bus outputs simply hold while the target stalls.
          if (!waitrequest) begin
            if (idx == LAST_IDX) begin
              chipselect <= 1'b0;
              write      <= 1'b0;
              address    <= 9'd0;
              writedata  <= 32'd0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              idx       <= idx + 2'd1;
              address   <= next_addr;
              writedata <= next_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scroll_writer.sv
// Directed self-checking bench for obstacle_scroll_writer; adapts to the SCORE_WRITE_EN build.
module tb_obstacle_scroll_writer;

`ifdef SCORE_WRITE_EN
  localparam int NWR = 3;
`else
  localparam int NWR = 2;
`endif

  logic        clk;
  logic        reset_n;
  logic        vga_vs;
  logic        enable;
  logic [3:0]  speed;
  logic        waitrequest;
  logic        chipselect;
  logic        write;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic        busy;
  logic        overrun;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] spd;
    logic       en;
    logic       drop;
    int         nwr;
    logic [9:0] cac;
    logic [9:0] god;
    logic [3:0] sc;
  } vec_t;

  wr_t  seen[$];
  vec_t vecs[7];
  int   total;
  int   bad;

  obstacle_scroll_writer #(
    .SCREEN_W (10'd640),
    .CAC_INIT (10'd500),
    .GOD_INIT (10'd100)
`ifdef SCORE_WRITE_EN
    ,
    .SCORE_FRAMES (2)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vga_vs      (vga_vs),
    .enable      (enable),
    .speed       (speed),
    .waitrequest (waitrequest),
    .chipselect  (chipselect),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed bus write, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (reset_n && write && !waitrequest) begin
      w.addr = address;
      w.data = writedata;
      seen.push_back(w);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] spd, input logic en, input logic drop);
    seen.delete();
    @(posedge clk); #1;
    speed  = spd;
    enable = en;
    vga_vs = 1'b0;
    if (drop) begin
      @(posedge clk); #1;
      enable = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_output(input string tag, input int nexp, input logic [9:0] cac,
                              input logic [9:0] god, input logic [3:0] sc);
    logic [8:0]  ea [3];
    logic [31:0] ed [3];
    ea[0] = 9'd6;  ea[1] = 9'd8;  ea[2] = 9'd10;
    ed[0] = {22'd0, cac};
    ed[1] = {22'd0, god};
    ed[2] = {28'd0, sc};
    check({tag, " writes"}, seen.size(), nexp);
    for (int i = 0; i < nexp && i < seen.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), {23'd0, seen[i].addr}, {23'd0, ea[i]});
      check($sformatf("%s data%0d", tag, i), seen[i].data, ed[i]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vga_vs  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] score_seq [20];
    logic [3:0] exp_s;

    total = 0;
    bad   = 0;
    reset_n = 1'b0; vga_vs = 1'b1; enable = 1'b0; speed = 4'd0; waitrequest = 1'b0;

    // Frames continue from the hand-checked first frame: cac 498, god 98, one frame counted.
    vecs[0] = '{4'd0,  1'b1, 1'b0, NWR, 10'd498, 10'd98, 4'd1};
    vecs[1] = '{4'd5,  1'b1, 1'b0, NWR, 10'd493, 10'd93, 4'd1};
    vecs[2] = '{4'd7,  1'b0, 1'b0, 0,   10'd493, 10'd93, 4'd1};
    vecs[3] = '{4'd15, 1'b1, 1'b0, NWR, 10'd478, 10'd78, 4'd2};
    vecs[4] = '{4'd15, 1'b1, 1'b1, NWR, 10'd463, 10'd63, 4'd2};
    vecs[5] = '{4'd1,  1'b1, 1'b0, NWR, 10'd462, 10'd62, 4'd3};
    vecs[6] = '{4'd9,  1'b1, 1'b0, NWR, 10'd453, 10'd53, 4'd3};
    score_seq = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5,
                  4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset write", {31'd0, write}, 32'd0);
    check("reset chipselect", {31'd0, chipselect}, 32'd0);
    check("reset address", {23'd0, address}, 32'd0);
    check("reset writedata", writedata, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // First frame: cycle-exact latency of UPDATE and the back-to-back writes.
    $display("[TB] first frame latency");
    seen.delete();
    @(posedge clk); #1;
    speed = 4'd2; enable = 1'b1; vga_vs = 1'b0;
    @(negedge clk);
    check("N busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("N+1 busy", {31'd0, busy}, 32'd1);
    check("N+1 write", {31'd0, write}, 32'd0);
    @(negedge clk);
    check("N+2 write", {31'd0, write}, 32'd1);
    check("N+2 chipselect", {31'd0, chipselect}, 32'd1);
    check("N+2 address", {23'd0, address}, 32'd6);
    check("N+2 data", writedata, 32'd498);
    @(negedge clk);
    check("N+3 address", {23'd0, address}, 32'd8);
    check("N+3 data", writedata, 32'd98);
`ifdef SCORE_WRITE_EN
    @(negedge clk);
    check("N+4 address", {23'd0, address}, 32'd10);
    check("N+4 data", writedata, 32'd0);
`endif
    @(negedge clk);
    check("end busy", {31'd0, busy}, 32'd0);
    check("end write", {31'd0, write}, 32'd0);
    @(posedge clk); #1 vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    check_output("frame1", NWR, 10'd498, 10'd98, 4'd0);

    $display("[TB] table vectors");
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].spd, vecs[v].en, vecs[v].drop);
      check_output($sformatf("vec%0d", v), vecs[v].nwr, vecs[v].cac, vecs[v].god, vecs[v].sc);
    end

    // Reset while a write is on the bus must drop it on the next edge.
    $display("[TB] reset mid-sequence");
    @(posedge clk); #1;
    speed = 4'd1; enable = 1'b1; vga_vs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst write before", {31'd0, write}, 32'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst write", {31'd0, write}, 32'd0);
    check("midrst chipselect", {31'd0, chipselect}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    vga_vs = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] wrap and score run");
    for (int k = 1; k <= 51; k++) begin
      apply_stimulus(4'd2, 1'b1, 1'b0);
      if (k <= 20) exp_s = score_seq[k-1];
      else         exp_s = 4'((k / 2) % 10);
      if (k == 50)      check_output("wrap50", NWR, 10'd400, 10'd0, 4'd5);
      else if (k == 51) check_output("wrap51", NWR, 10'd398, 10'd638, 4'd5);
      else check_output($sformatf("run%0d", k), NWR, 10'(500 - 2 * k), 10'(100 - 2 * k), exp_s);
    end

    // Stall the godzilla write for three cycles and watch it hold.
    $display("[TB] wait states");
    seen.delete();
    @(posedge clk); #1;
    speed = 4'd0; enable = 1'b1; vga_vs = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == 3) waitrequest = 1'b0;
      end
      @(negedge clk);
      check($sformatf("hold%0d write", i), {31'd0, write}, 32'd1);
      check($sformatf("hold%0d address", i), {23'd0, address}, 32'd8);
      check($sformatf("hold%0d data", i), writedata, 32'd638);
    end
    @(negedge clk);
`ifdef SCORE_WRITE_EN
    check("after hold address", {23'd0, address}, 32'd10);
    check("after hold write", {31'd0, write}, 32'd1);
`else
    check("after hold write", {31'd0, write}, 32'd0);
    check("after hold busy", {31'd0, busy}, 32'd0);
`endif
    repeat (4) @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (2) @(posedge clk);
    check_output("waitst", NWR, 10'd398, 10'd638, 4'd6);
    check("waitst overrun", {31'd0, overrun}, 32'd0);

    // Second frame edge while the sequence is stalled.
    $display("[TB] overrun");
    seen.delete();
    @(posedge clk); #1;
    waitrequest = 1'b1; speed = 4'd0; enable = 1'b1; vga_vs = 1'b0;
    repeat (4) @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1 vga_vs = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("overrun set", {31'd0, overrun}, 32'd1);
    check("overrun busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 waitrequest = 1'b0; vga_vs = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("overrun sticky", {31'd0, overrun}, 32'd1);
    check("overrun idle", {31'd0, busy}, 32'd0);
    check_output("overrun", NWR, 10'd398, 10'd638, 4'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
